// File: rtl/multicycle_core.sv
// multicycle_core: multi-cycle RV32I/RV64I-subset processor with internal memories.
// Each instruction steps through FETCH/DECODE/EXEC/MEM/WB; the ALU, register file and
// immediate generator are shared across those states.
// Ports:
//   CLK, RST                    clock, synchronous active-high reset
//   start                       leave IDLE/HALT and run from pc 0
//   imem_we/imem_addr/imem_wdata program-load port, accepted only in IDLE or HALT
//   pc                          current byte PC
//   busy                        high in every state except IDLE and HALT
//   retire                      high during the last state of each instruction
//   instret                     retired-instruction count
//   halted, trap                HALT indication; trap=1 for illegal/misaligned, 0 for ebreak
module multicycle_core #(
   parameter int XLEN       = 64,
   parameter int IMEM_DEPTH = 256,
   parameter int DMEM_DEPTH = 256
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic                          start,
   input  logic                          imem_we,
   input  logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
   input  logic [31:0]                   imem_wdata,
   output logic [XLEN-1:0]               pc,
   output logic                          busy,
   output logic                          retire,
   output logic [31:0]                   instret,
   output logic                          halted,
   output logic                          trap
);
   localparam int IAW = $clog2(IMEM_DEPTH);
   localparam int DAW = $clog2(DMEM_DEPTH);
   localparam int K   = (XLEN == 64) ? 3 : 2;
   localparam logic [2:0] MEM_F3 = (XLEN == 64) ? 3'b011 : 3'b010;

   typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

   state_t          state_q;
   logic [31:0]     imem_q [IMEM_DEPTH];
   logic [XLEN-1:0] rf_q [32];
   logic [XLEN-1:0] dmem_q [DMEM_DEPTH];
   logic [31:0]     ir_q, instret_q;
   logic [XLEN-1:0] pc_q, a_q, b_q, imm_q, alu_q, mdr_q;
   logic            busy_q, retire_q, halted_q, trap_q;

   logic [6:0]      opc, f7;
   logic [4:0]      rd, rs1, rs2;
   logic [2:0]      f3;
   logic            is_r, is_i, is_ld, is_st, is_br, is_jal, is_ebreak, legal, taken;
   logic [XLEN-1:0] imm_d, op_b, alu_d, pc_inc, pc_tgt;
   logic [DAW-1:0]  dmem_idx;

   assign opc = ir_q[6:0];
   assign rd  = ir_q[11:7];
   assign f3  = ir_q[14:12];
   assign rs1 = ir_q[19:15];
   assign rs2 = ir_q[24:20];
   assign f7  = ir_q[31:25];

   // Only sub may carry funct7=0100000; every other R-type op needs funct7=0.
   assign is_r      = opc == 7'b0110011 &&
                      ((f7 == 7'b0000000 && (f3 == 3'b000 || f3 == 3'b111 || f3 == 3'b110)) ||
                       (f7 == 7'b0100000 && f3 == 3'b000));
   assign is_i      = opc == 7'b0010011 && (f3 == 3'b000 || f3 == 3'b111 || f3 == 3'b110);
   assign is_ld     = opc == 7'b0000011 && f3 == MEM_F3;
   assign is_st     = opc == 7'b0100011 && f3 == MEM_F3;
   assign is_br     = opc == 7'b1100011 && f3[2:1] == 2'b00;
   assign is_jal    = opc == 7'b1101111;
   assign is_ebreak = ir_q == 32'h0010_0073;
   assign legal     = is_r | is_i | is_ld | is_st | is_br | is_jal;

   always_comb
      imm_d = is_st  ? XLEN'($signed({ir_q[31:25], ir_q[11:7]}))
            : is_br  ? XLEN'($signed({ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0}))
            : is_jal ? XLEN'($signed({ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0}))
            :          XLEN'($signed(ir_q[31:20]));

   assign op_b = is_r ? b_q : imm_q;

   // Loads and stores fall through to the add path for their address.
   always_comb
      alu_d = (is_r && f7[5])                      ? a_q - op_b
            : ((is_r || is_i) && f3 == 3'b111)     ? a_q & op_b
            : ((is_r || is_i) && f3 == 3'b110)     ? a_q | op_b
            :                                        a_q + op_b;

   assign taken    = (a_q == b_q) ^ f3[0];
   assign pc_inc   = pc_q + XLEN'(4);
   assign pc_tgt   = pc_q + imm_q;
   assign dmem_idx = alu_q[DAW+K-1:K];

   always_ff @(posedge CLK)
      if (imem_we && (state_q == IDLE || state_q == HALT)) imem_q[imem_addr] <= imem_wdata;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= IDLE;
         pc_q      <= '0;
         instret_q <= '0;
         busy_q    <= 1'b0;
         retire_q  <= 1'b0;
         halted_q  <= 1'b0;
         trap_q    <= 1'b0;
         ir_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         imm_q     <= '0;
         alu_q     <= '0;
         mdr_q     <= '0;
         for (int i = 0; i < 32; i++) rf_q[i] <= '0;
         for (int i = 0; i < DMEM_DEPTH; i++) dmem_q[i] <= '0;
      end else begin
         // retire_q marks the final state, so the count advances on that state's exit edge.
         retire_q <= 1'b0;
         if (retire_q) instret_q <= instret_q + 32'd1;
         case (state_q)
            IDLE, HALT: if (start) begin
               state_q   <= FETCH;
               pc_q      <= '0;
               instret_q <= '0;
               busy_q    <= 1'b1;
               halted_q  <= 1'b0;
               trap_q    <= 1'b0;
            end
            FETCH: if (pc_q[1:0] != 2'b00) begin
               state_q  <= HALT;
               busy_q   <= 1'b0;
               halted_q <= 1'b1;
               trap_q   <= 1'b1;
            end else begin
               ir_q    <= imem_q[pc_q[IAW+1:2]];
               state_q <= DECODE;
            end
            DECODE: begin
               a_q   <= rf_q[rs1];
               b_q   <= rf_q[rs2];
               imm_q <= imm_d;
               if (!legal) begin
                  state_q  <= HALT;
                  busy_q   <= 1'b0;
                  halted_q <= 1'b1;
                  trap_q   <= !is_ebreak;
               end else begin
                  state_q  <= EXEC;
                  retire_q <= is_br;
               end
            end
            EXEC: begin
               alu_q <= is_jal ? pc_inc : alu_d;
               if (is_br) begin
                  pc_q    <= taken ? pc_tgt : pc_inc;
                  state_q <= FETCH;
               end else if (is_ld || is_st) begin
                  state_q  <= MEM;
                  retire_q <= is_st;
               end else begin
                  if (is_jal) pc_q <= pc_tgt;
                  state_q  <= WB;
                  retire_q <= 1'b1;
               end
            end
            MEM: if (is_st) begin
               dmem_q[dmem_idx] <= b_q;
               pc_q             <= pc_inc;
               state_q          <= FETCH;
            end else begin
               mdr_q    <= dmem_q[dmem_idx];
               state_q  <= WB;
               retire_q <= 1'b1;
            end
            WB: begin
               if (rd != 5'd0) rf_q[rd] <= is_ld ? mdr_q : alu_q;
               if (!is_jal) pc_q <= pc_inc;
               state_q <= FETCH;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign pc      = pc_q;
   assign busy    = busy_q;
   assign retire  = retire_q;
   assign instret = instret_q;
   assign halted  = halted_q;
   assign trap    = trap_q;
endmodule
